pci_sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO built from a synchronous-read storage array; a generalised successor to the 16x1 fixed-size SRAM.
- Buffers host-to-PCI and PCI-to-host data or command words inside the pci_clk domain.
- Adds features the fixed SRAM lacks:
  - configurable width and depth;
  - full/empty tracking with overflow and underflow protection;
  - occupancy count and watermarks;
  - sticky error flags;
  - synchronous flush;
  - a defined read-data value when no read occurs. The fixed SRAM returns garbage in that case.

---
 rtl/pci_sync_fifo_param_if.sv | 37 +++
 rtl/pci_sync_fifo_param.sv | 105 ++++++++++
 tb/tb_pci_sync_fifo_param.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pci_sync_fifo_param_if.sv
// Handshake and status bundle for the pci_clk-domain FIFO.
// master = the client driving requests, slave = the FIFO itself.
interface pci_sync_fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4
);
  // Requests are single-cycle strobes sampled on the rising pci_clk edge;
  // acceptance is decided by the FIFO from full/empty/flush in that same
  // cycle. read_data_valid pulses for exactly one cycle, the cycle after
  // an accepted read.
  logic                  flush;
  logic                  write_capture_data;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_enable;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_BITS:0]    count;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output flush, write_capture_data, write_data, read_enable, clear_err,
    input  read_data, read_data_valid, full, empty, almost_full,
           almost_empty, count, overflow_err, underflow_err
  );

  modport slave (
    input  flush, write_capture_data, write_data, read_enable, clear_err,
    output read_data, read_data_valid, full, empty, almost_full,
           almost_empty, count, overflow_err, underflow_err
  );
endinterface

// File: rtl/pci_sync_fifo_param.sv
// Single-clock parametrised FIFO with explicit occupancy count, watermarks,
// sticky overflow/underflow flags, synchronous flush and registered read data.
module pci_sync_fifo_param #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_BITS          = 4,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                   pci_clk,
  input  logic                   async_reset,
  pci_sync_fifo_param_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CNT_W = ADDR_BITS + 1;
  localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0]     CNT_ONE = 1;
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_AF   = CNT_W'(ALMOST_FULL_LEVEL);
  localparam logic [CNT_W-1:0]     CNT_AE   = CNT_W'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0]  wptr_q, wptr_d;
  logic [ADDR_BITS-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic full, empty, wr_ok, rd_ok, ovf_set, unf_set;

  // Flags decode straight from the count so they can never disagree with it.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_ok   = bus.read_enable & ~bus.flush & ~empty;
  assign wr_ok   = bus.write_capture_data & ~bus.flush & (~full | rd_ok);
  assign ovf_set = bus.write_capture_data & full & ~rd_ok & ~bus.flush;
  assign unf_set = bus.read_enable & empty & ~bus.flush;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_set | (ovf_q & ~bus.clear_err);
    unf_d    = unf_set | (unf_q & ~bus.clear_err);

    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + PTR_ONE;
      if (rd_ok) begin
        rptr_d   = rptr_q + PTR_ONE;
        rdata_d  = mem[rptr_q];
        rvalid_d = 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge pci_clk or posedge async_reset) begin
    if (async_reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge pci_clk) begin
    if (wr_ok) mem[wptr_q] <= bus.write_data;
  end

  assign bus.read_data       = rdata_q;
  assign bus.read_data_valid = rvalid_q;
  assign bus.full            = full;
  assign bus.empty           = empty;
  assign bus.almost_full     = (count_q >= CNT_AF);
  assign bus.almost_empty    = (count_q <= CNT_AE);
  assign bus.count           = count_q;
  assign bus.overflow_err    = ovf_q;
  assign bus.underflow_err   = unf_q;
endmodule

// File: tb/tb_pci_sync_fifo_param.sv
// Scoreboard bench for pci_sync_fifo_param at DATA_WIDTH=8, DEPTH=4.
module tb_pci_sync_fifo_param;
  localparam int DW  = 8;
  localparam int AB  = 2;
  localparam int DEP = 4;
  localparam int AFL = 3;
  localparam int AEL = 1;

  logic clk;
  logic rst;

  pci_sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

  pci_sync_fifo_param #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB),
    .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) dut (
    .pci_clk(clk),
    .async_reset(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rdata;
  logic          m_ovf;
  logic          m_unf;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_valid);
    int c;
    c = exp_q.size();
    check_eq({tag, ".count"},   32'(bus.count), 32'(c));
    check_eq({tag, ".empty"},   32'(bus.empty), 32'(c == 0));
    check_eq({tag, ".full"},    32'(bus.full), 32'(c == DEP));
    check_eq({tag, ".afull"},   32'(bus.almost_full), 32'(c >= AFL));
    check_eq({tag, ".aempty"},  32'(bus.almost_empty), 32'(c <= AEL));
    check_eq({tag, ".ovf"},     32'(bus.overflow_err), 32'(m_ovf));
    check_eq({tag, ".unf"},     32'(bus.underflow_err), 32'(m_unf));
    check_eq({tag, ".valid"},   32'(bus.read_data_valid), 32'(exp_valid));
    check_eq({tag, ".rdata"},   32'(bus.read_data), 32'(m_rdata));
  endtask

  // driver: one clock cycle of stimulus, model update, then post-edge checks
  task automatic do_cycle(input string tag, input logic wr, input logic [DW-1:0] wd,
                          input logic rd, input logic fl, input logic clr);
    logic m_full, m_empty, rd_ok, wr_ok;
    m_full  = (exp_q.size() == DEP);
    m_empty = (exp_q.size() == 0);
    rd_ok   = rd & ~fl & ~m_empty;
    wr_ok   = wr & ~fl & (~m_full | rd_ok);
    bus.write_capture_data = wr;
    bus.write_data         = wd;
    bus.read_enable        = rd;
    bus.flush              = fl;
    bus.clear_err          = clr;
    m_ovf = (wr & m_full & ~rd_ok & ~fl) | (m_ovf & ~clr);
    m_unf = (rd & m_empty & ~fl) | (m_unf & ~clr);
    if (wr_ok) exp_q.push_back(wd);
    @(posedge clk);
    #1;
    bus.write_capture_data = 1'b0;
    bus.read_enable        = 1'b0;
    bus.flush              = 1'b0;
    bus.clear_err          = 1'b0;
    if (rd_ok) m_rdata = exp_q.pop_front();
    if (fl) exp_q.delete();
    check_status(tag, rd_ok);
  endtask

  task automatic wr_word(input string tag, input logic [DW-1:0] d);
    do_cycle(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_word(input string tag);
    do_cycle(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  logic [DW-1:0] fill_a [4];

  initial begin
    fill_a[0] = 8'h11; fill_a[1] = 8'h22; fill_a[2] = 8'h33; fill_a[3] = 8'h44;
    bus.flush = 1'b0;
    bus.write_capture_data = 1'b0;
    bus.write_data = '0;
    bus.read_enable = 1'b0;
    bus.clear_err = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_status("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fill to full, then overflow attempt
    for (int i = 0; i < 4; i++) wr_word("fill", fill_a[i]);
    wr_word("ovf_write", 8'h55);
    for (int i = 0; i < 4; i++) rd_word("drain");
    do_cycle("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // underflow, then clear
    rd_word("underflow");
    do_cycle("clear_err", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // full with simultaneous read and write
    for (int i = 0; i < 4; i++) wr_word("refill", 8'(i + 1));
    do_cycle("full_rw", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rd_word("drain_a5");
    check_eq("a5_last", 32'(m_rdata), 32'h0000_00A5);

    // interleaved traffic across pointer wrap
    for (int i = 0; i < 10; i++)
      do_cycle("wrap", 1'b1, 8'($urandom_range(0, 255)), (i % 2 == 1), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) rd_word("wrap_drain");

    // write into empty with simultaneous read: read refused, word kept
    do_cycle("wr_rd_empty", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    rd_word("after_empty_wr");

    // flush with three words and a concurrent write
    for (int i = 0; i < 3; i++) wr_word("pre_flush", 8'($urandom_range(0, 255)));
    do_cycle("flush", 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    wr_word("post_flush", 8'h9E);
    rd_word("post_flush_rd");

    // async reset between edges, mid-burst
    wr_word("burst", 8'h5A);
    wr_word("burst", 8'h6B);
    bus.write_capture_data = 1'b1;
    bus.write_data = 8'h7C;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst.count", 32'(bus.count), 32'd0);
    check_eq("arst.empty", 32'(bus.empty), 32'd1);
    check_eq("arst.rdata", 32'(bus.read_data), 32'd0);
    check_eq("arst.valid", 32'(bus.read_data_valid), 32'd0);
    bus.write_capture_data = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_status("post_arst", 1'b0);
    wr_word("post_arst_wr", 8'hC3);
    rd_word("post_arst_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
